// File: rtl/hart_dbg_ctl_if.sv
// ---------------------------------------------------------------------------
// hart_dbg_ctl_if
//
// Bundle of every signal between the debug module / cores and the multi-hart
// debug-mode controller. The controller connects through the slave modport;
// whatever drives the DM requests and core status (a DM, or a testbench)
// connects through the master modport.
//
// Parameters
//   NHARTS  number of harts controlled (1..32)
//   XLEN    PC / DPC width
//
// Request / status toward the controller (master -> slave)
//   hart_sel       [NHARTS]        DM hart-select mask (hasel window applied)
//   halt_req                       level, halt the selected harts
//   resume_req                     one-cycle pulse, resume the selected harts
//   ack_havereset                  pulse, clear havereset of selected harts
//   haltonreset    [NHARTS]        per-hart resethaltreq configuration
//   step_en        [NHARTS]        per-hart DCSR.step
//   ebreak_hit     [NHARTS]        ebreak retiring with debug entry enabled
//   instr_end      [NHARTS]        instruction retired / interrupt taken
//   core_halted    [NHARTS]        core microcode reached its halted state
//   core_resumed   [NHARTS]        core has left its resuming state
//   pc_reg         [NHARTS*XLEN]   current PC, hart i at [i*XLEN +: XLEN]
//   pc_next        [NHARTS*XLEN]   next PC, same packing
//
// Controller results (slave -> master)
//   debug          [NHARTS]        hart is in, or is entering, debug mode
//   resume_go      [NHARTS]        core should run its resume sequence
//   halted         [NHARTS]        hart is halted
//   resumeack      [NHARTS]        sticky resume acknowledge
//   havereset      [NHARTS]        sticky have-reset flag
//   dpc_write      [NHARTS]        one-cycle DPC / DCSR.cause write strobe
//   dpc_out        [NHARTS*XLEN]   DPC value to write
//   cause_out      [NHARTS*3]      DCSR.cause value to write
//   anyhalted / allhalted          OR / AND of halted over selected harts
// ---------------------------------------------------------------------------
interface hart_dbg_ctl_if #(
    parameter int NHARTS = 2,
    parameter int XLEN   = 32
);
    logic [NHARTS-1:0]      hart_sel;
    logic                   halt_req;
    logic                   resume_req;
    logic                   ack_havereset;
    logic [NHARTS-1:0]      haltonreset;
    logic [NHARTS-1:0]      step_en;
    logic [NHARTS-1:0]      ebreak_hit;
    logic [NHARTS-1:0]      instr_end;
    logic [NHARTS-1:0]      core_halted;
    logic [NHARTS-1:0]      core_resumed;
    logic [NHARTS*XLEN-1:0] pc_reg;
    logic [NHARTS*XLEN-1:0] pc_next;

    logic [NHARTS-1:0]      debug;
    logic [NHARTS-1:0]      resume_go;
    logic [NHARTS-1:0]      halted;
    logic [NHARTS-1:0]      resumeack;
    logic [NHARTS-1:0]      havereset;
    logic [NHARTS-1:0]      dpc_write;
    logic [NHARTS*XLEN-1:0] dpc_out;
    logic [NHARTS*3-1:0]    cause_out;
    logic                   anyhalted;
    logic                   allhalted;

    modport master (
        output hart_sel, halt_req, resume_req, ack_havereset, haltonreset,
               step_en, ebreak_hit, instr_end, core_halted, core_resumed,
               pc_reg, pc_next,
        input  debug, resume_go, halted, resumeack, havereset, dpc_write,
               dpc_out, cause_out, anyhalted, allhalted
    );

    modport slave (
        input  hart_sel, halt_req, resume_req, ack_havereset, haltonreset,
               step_en, ebreak_hit, instr_end, core_halted, core_resumed,
               pc_reg, pc_next,
        output debug, resume_go, halted, resumeack, havereset, dpc_write,
               dpc_out, cause_out, anyhalted, allhalted
    );
endinterface

// File: rtl/hart_dbg_ctl.sv
// ---------------------------------------------------------------------------
// hart_dbg_ctl
//
// Multi-hart debug-mode controller. Every hart owns an independent
// RUN -> HALTING -> HALTED -> RESUMING -> RUN state machine. While a hart is
// in RUN, the highest-priority debug-entry condition (ebreak, resethaltreq,
// haltreq, step) is resolved combinationally; in that same cycle the hart
// raises debug and a one-cycle dpc_write strobe carrying the DPC and
// DCSR.cause to capture, and the state moves to HALTING on the next edge.
// The controller also keeps the sticky resumeack / havereset bits and
// reduces halted over the hart-select mask into anyhalted / allhalted.
//
// Ports
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    hart_dbg_ctl_if.slave, all request, status and result signals
//
// Parameters
//   NHARTS  number of harts (1..32), must match the interface instance
//   XLEN    PC / DPC width, must match the interface instance
// ---------------------------------------------------------------------------
module hart_dbg_ctl #(
    parameter int NHARTS = 2,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    hart_dbg_ctl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALTING  = 2'd1,
        ST_HALTED   = 2'd2,
        ST_RESUMING = 2'd3
    } state_e;

    // DCSR.cause encodings
    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] CAUSE_STEP      = 3'd4;
    localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

    state_e                 state_q [NHARTS];
    logic                   first_q;
    logic [NHARTS-1:0]      busy_q;       // state != RUN, registered with the state
    logic [NHARTS-1:0]      halted_q;
    logic [NHARTS-1:0]      resume_go_q;
    logic [NHARTS-1:0]      resumeack_q;
    logic [NHARTS-1:0]      havereset_q;

    logic [NHARTS-1:0]      entry;
    logic [NHARTS-1:0]      resume_hit;
    logic [NHARTS*XLEN-1:0] dpc_flat;
    logic [NHARTS*3-1:0]    cause_flat;

    // A simultaneous halt request cancels the resume pulse for every hart.
    assign resume_hit = (bus.resume_req && !bus.halt_req) ? bus.hart_sel : '0;

    // -----------------------------------------------------------------------
    // Debug-entry resolution. Only harts in RUN can enter; the if/else chain
    // encodes the priority ebreak > resethaltreq > haltreq > step. Entry is
    // masked while rst_n is low so no write strobe fires during reset.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a missed path infers a latch.
        entry      = '0;
        cause_flat = '0;
        dpc_flat   = bus.pc_reg;
        for (int i = 0; i < NHARTS; i++) begin
            cause_flat[i*3 +: 3] = CAUSE_NONE;
            if (rst_n && state_q[i] == ST_RUN) begin
                if (bus.ebreak_hit[i]) begin
                    entry[i]             = 1'b1;
                    cause_flat[i*3 +: 3] = CAUSE_EBREAK;
                end else if (first_q && bus.haltonreset[i]) begin
                    entry[i]             = 1'b1;
                    cause_flat[i*3 +: 3] = CAUSE_RESETHALT;
                end else if (bus.halt_req && bus.hart_sel[i]) begin
                    entry[i]             = 1'b1;
                    cause_flat[i*3 +: 3] = CAUSE_HALTREQ;
                    // The retiring instruction completes, so DPC points past it.
                    if (bus.instr_end[i]) begin
                        dpc_flat[i*XLEN +: XLEN] = bus.pc_next[i*XLEN +: XLEN];
                    end
                end else if (bus.step_en[i] && bus.instr_end[i]) begin
                    entry[i]                 = 1'b1;
                    cause_flat[i*3 +: 3]     = CAUSE_STEP;
                    dpc_flat[i*XLEN +: XLEN] = bus.pc_next[i*XLEN +: XLEN];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-hart state machines and sticky status. first_q is high during reset
    // and for exactly the first cycle after rst_n rises, which is the only
    // window in which resethaltreq may trigger.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            first_q     <= 1'b1;
            busy_q      <= '0;
            halted_q    <= '0;
            resume_go_q <= '0;
            resumeack_q <= '0;
            havereset_q <= '1;
            for (int i = 0; i < NHARTS; i++) begin
                state_q[i] <= ST_RUN;
            end
        end else begin
            first_q <= 1'b0;
            for (int i = 0; i < NHARTS; i++) begin
                unique case (state_q[i])
                    ST_RUN: begin
                        if (entry[i]) begin
                            state_q[i] <= ST_HALTING;
                            busy_q[i]  <= 1'b1;
                        end
                    end
                    ST_HALTING: begin
                        if (bus.core_halted[i]) begin
                            state_q[i]  <= ST_HALTED;
                            halted_q[i] <= 1'b1;
                        end
                    end
                    ST_HALTED: begin
                        if (resume_hit[i]) begin
                            state_q[i]     <= ST_RESUMING;
                            halted_q[i]    <= 1'b0;
                            resume_go_q[i] <= 1'b1;
                            resumeack_q[i] <= 1'b0;
                        end
                    end
                    ST_RESUMING: begin
                        if (bus.core_resumed[i]) begin
                            state_q[i]     <= ST_RUN;
                            busy_q[i]      <= 1'b0;
                            resume_go_q[i] <= 1'b0;
                            resumeack_q[i] <= 1'b1;
                        end
                    end
                    default: begin
                        state_q[i] <= ST_RUN;
                    end
                endcase

                if (bus.ack_havereset && bus.hart_sel[i]) begin
                    havereset_q[i] <= 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. debug rises combinationally in the entry cycle, then is held
    // by the registered busy flag until the hart is back in RUN.
    // -----------------------------------------------------------------------
    assign bus.debug     = busy_q | entry;
    assign bus.halted    = halted_q;
    assign bus.resume_go = resume_go_q;
    assign bus.resumeack = resumeack_q;
    assign bus.havereset = havereset_q;
    assign bus.dpc_write = entry;
    assign bus.dpc_out   = dpc_flat;
    assign bus.cause_out = cause_flat;

    assign bus.anyhalted = |(halted_q & bus.hart_sel);
    assign bus.allhalted = (bus.hart_sel != '0) &&
                           ((halted_q & bus.hart_sel) == bus.hart_sel);

endmodule

// File: tb/tb_hart_dbg_ctl.sv
// ---------------------------------------------------------------------------
// tb_hart_dbg_ctl
//
// Self-checking bench for hart_dbg_ctl with two harts. Directed scenarios
// exercise reset/resethaltreq, group halt, selective resume, single step,
// entry priority and the halt-beats-resume rule; a randomized run compares
// every output each cycle against a behavioural model that tracks each hart
// as a set of flags (in debug, halted, resuming).
// ---------------------------------------------------------------------------
module tb_hart_dbg_ctl;

    localparam int NH = 2;
    localparam int XL = 32;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    hart_dbg_ctl_if #(.NHARTS(NH), .XLEN(XL)) bus ();

    hart_dbg_ctl #(.NHARTS(NH), .XLEN(XL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: per hart, "in debug" covers HALTING/HALTED/RESUMING,
    // with halted / resuming distinguishing the latter two.
    // ------------------------------------------------------------------
    logic [NH-1:0] m_debug;
    logic [NH-1:0] m_halted;
    logic [NH-1:0] m_resuming;
    logic [NH-1:0] m_ack;
    logic [NH-1:0] m_hr;
    logic          m_first;

    function automatic bit model_entry(input int i, output logic [2:0] c,
                                       output logic [XL-1:0] d);
        logic [XL-1:0] pr;
        logic [XL-1:0] pn;
        pr = bus.pc_reg[i*XL +: XL];
        pn = bus.pc_next[i*XL +: XL];
        c  = 3'd0;
        d  = pr;
        if (!rst_n || m_debug[i]) return 1'b0;
        if (bus.ebreak_hit[i]) begin
            c = 3'd1; d = pr; return 1'b1;
        end
        if (m_first && bus.haltonreset[i]) begin
            c = 3'd5; d = pr; return 1'b1;
        end
        if (bus.halt_req && bus.hart_sel[i]) begin
            c = 3'd3; d = bus.instr_end[i] ? pn : pr; return 1'b1;
        end
        if (bus.step_en[i] && bus.instr_end[i]) begin
            c = 3'd4; d = pn; return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance the model over one clock edge using the inputs currently applied,
    // then return at the following falling edge.
    task automatic tick();
        logic [NH-1:0] n_debug, n_halted, n_resuming, n_ack, n_hr;
        logic [2:0]    c;
        logic [XL-1:0] d;
        n_debug    = m_debug;
        n_halted   = m_halted;
        n_resuming = m_resuming;
        n_ack      = m_ack;
        n_hr       = m_hr;
        for (int i = 0; i < NH; i++) begin
            if (model_entry(i, c, d)) begin
                n_debug[i] = 1'b1;
            end else if (m_debug[i] && !m_halted[i] && !m_resuming[i]) begin
                if (bus.core_halted[i]) n_halted[i] = 1'b1;
            end else if (m_halted[i]) begin
                if (bus.resume_req && bus.hart_sel[i] && !bus.halt_req) begin
                    n_halted[i]   = 1'b0;
                    n_resuming[i] = 1'b1;
                    n_ack[i]      = 1'b0;
                end
            end else if (m_resuming[i]) begin
                if (bus.core_resumed[i]) begin
                    n_debug[i]    = 1'b0;
                    n_resuming[i] = 1'b0;
                    n_ack[i]      = 1'b1;
                end
            end
            if (bus.ack_havereset && bus.hart_sel[i]) n_hr[i] = 1'b0;
        end
        @(posedge clk);
        if (!rst_n) begin
            m_debug = '0; m_halted = '0; m_resuming = '0; m_ack = '0; m_hr = '1;
            m_first = 1'b1;
        end else begin
            m_debug = n_debug; m_halted = n_halted; m_resuming = n_resuming;
            m_ack = n_ack; m_hr = n_hr; m_first = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.hart_sel      = '0;
        bus.halt_req      = 1'b0;
        bus.resume_req    = 1'b0;
        bus.ack_havereset = 1'b0;
        bus.haltonreset   = '0;
        bus.step_en       = '0;
        bus.ebreak_hit    = '0;
        bus.instr_end     = '0;
        bus.core_halted   = '0;
        bus.core_resumed  = '0;
        bus.pc_reg        = '0;
        bus.pc_next       = '0;
    endtask

    // Leaves the bench at a falling edge in the first cycle after release.
    task automatic do_reset(input logic [NH-1:0] hor);
        clear_inputs();
        bus.haltonreset = hor;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        bus.haltonreset = 2'b10;
        bus.pc_reg = {32'h1234_5678, 32'h0000_0040};
        rst_n = 1'b0;
        tick();
        tick();
        #1;
        vectors++; if (bus.debug !== 2'b00) begin miscompares++; $display("FAIL reset_debug: got %b want 00", bus.debug); end
        vectors++; if (bus.halted !== 2'b00 || bus.resume_go !== 2'b00 || bus.resumeack !== 2'b00) begin miscompares++; $display("FAIL reset_status: halted %b resume_go %b resumeack %b want 00", bus.halted, bus.resume_go, bus.resumeack); end
        vectors++; if (bus.dpc_write !== 2'b00) begin miscompares++; $display("FAIL reset_dpc_write: got %b want 00", bus.dpc_write); end
        vectors++; if (bus.havereset !== 2'b11) begin miscompares++; $display("FAIL reset_havereset: got %b want 11", bus.havereset); end
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.dpc_write !== 2'b10 || bus.debug !== 2'b10) begin miscompares++; $display("FAIL resethalt_strobe: dpc_write %b debug %b want 10", bus.dpc_write, bus.debug); end
        vectors++; if (bus.cause_out[5:3] !== 3'd5 || bus.dpc_out[63:32] !== 32'h1234_5678) begin miscompares++; $display("FAIL resethalt_capture: cause %0d dpc %h want 5 12345678", bus.cause_out[5:3], bus.dpc_out[63:32]); end
        tick();
        #1;
        vectors++; if (bus.dpc_write !== 2'b00 || bus.debug !== 2'b10) begin miscompares++; $display("FAIL resethalt_halting: dpc_write %b debug %b want 00 10", bus.dpc_write, bus.debug); end
        bus.core_halted = 2'b10;
        #1;
        vectors++; if (bus.halted !== 2'b00) begin miscompares++; $display("FAIL resethalt_early: halted %b want 00", bus.halted); end
        tick();
        bus.core_halted = 2'b00;
        #1;
        vectors++; if (bus.halted !== 2'b10 || bus.debug !== 2'b10) begin miscompares++; $display("FAIL resethalt_halted: halted %b debug %b want 10 10", bus.halted, bus.debug); end
        bus.ack_havereset = 1'b1;
        bus.hart_sel = 2'b11;
        #1;
        vectors++; if (bus.havereset !== 2'b11) begin miscompares++; $display("FAIL havereset_hold: got %b want 11", bus.havereset); end
        tick();
        bus.ack_havereset = 1'b0;
        #1;
        vectors++; if (bus.havereset !== 2'b00) begin miscompares++; $display("FAIL havereset_ack: got %b want 00", bus.havereset); end
    endtask

    task automatic test_halt_both();
        do_reset(2'b00);
        tick();
        bus.hart_sel  = 2'b11;
        bus.halt_req  = 1'b1;
        bus.instr_end = 2'b01;
        bus.pc_reg    = {32'h0000_ABC0, 32'h0000_0100};
        bus.pc_next   = {32'h0000_ABC4, 32'h0000_0104};
        #1;
        vectors++; if (bus.dpc_write !== 2'b11 || bus.debug !== 2'b11) begin miscompares++; $display("FAIL halt_strobe: dpc_write %b debug %b want 11", bus.dpc_write, bus.debug); end
        vectors++; if (bus.dpc_out[31:0] !== 32'h104 || bus.cause_out[2:0] !== 3'd3) begin miscompares++; $display("FAIL halt_hart0: dpc %h cause %0d want 104 3", bus.dpc_out[31:0], bus.cause_out[2:0]); end
        vectors++; if (bus.dpc_out[63:32] !== 32'hABC0 || bus.cause_out[5:3] !== 3'd3) begin miscompares++; $display("FAIL halt_hart1: dpc %h cause %0d want abc0 3", bus.dpc_out[63:32], bus.cause_out[5:3]); end
        tick();
        bus.instr_end = 2'b00;
        #1;
        vectors++; if (bus.dpc_write !== 2'b00 || bus.anyhalted !== 1'b0) begin miscompares++; $display("FAIL halt_halting: dpc_write %b anyhalted %b want 00 0", bus.dpc_write, bus.anyhalted); end
        bus.core_halted = 2'b11;
        tick();
        bus.core_halted = 2'b00;
        bus.halt_req = 1'b0;
        #1;
        vectors++; if (bus.halted !== 2'b11 || bus.allhalted !== 1'b1 || bus.anyhalted !== 1'b1) begin miscompares++; $display("FAIL halt_both: halted %b all %b any %b want 11 1 1", bus.halted, bus.allhalted, bus.anyhalted); end
    endtask

    task automatic test_resume_one();
        bus.resume_req = 1'b1;
        bus.hart_sel = 2'b01;
        #1;
        vectors++; if (bus.resume_go !== 2'b00) begin miscompares++; $display("FAIL resume_early: resume_go %b want 00", bus.resume_go); end
        tick();
        bus.resume_req = 1'b0;
        bus.hart_sel = 2'b11;
        #1;
        vectors++; if (bus.resume_go !== 2'b01 || bus.resumeack !== 2'b00 || bus.halted !== 2'b10) begin miscompares++; $display("FAIL resume_go: resume_go %b ack %b halted %b want 01 00 10", bus.resume_go, bus.resumeack, bus.halted); end
        vectors++; if (bus.anyhalted !== 1'b1 || bus.allhalted !== 1'b0) begin miscompares++; $display("FAIL resume_reduce: any %b all %b want 1 0", bus.anyhalted, bus.allhalted); end
        bus.core_resumed = 2'b01;
        tick();
        bus.core_resumed = 2'b00;
        #1;
        vectors++; if (bus.resumeack !== 2'b01 || bus.debug !== 2'b10 || bus.resume_go !== 2'b00) begin miscompares++; $display("FAIL resume_done: ack %b debug %b resume_go %b want 01 10 00", bus.resumeack, bus.debug, bus.resume_go); end
    endtask

    task automatic test_step();
        bus.hart_sel = 2'b01;
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        bus.core_halted = 2'b01;
        tick();
        bus.core_halted = 2'b00;
        bus.step_en = 2'b01;
        bus.resume_req = 1'b1;
        tick();
        bus.resume_req = 1'b0;
        bus.core_resumed = 2'b01;
        tick();
        bus.core_resumed = 2'b00;
        #1;
        vectors++; if (bus.dpc_write !== 2'b00 || bus.debug[0] !== 1'b0) begin miscompares++; $display("FAIL step_run: dpc_write %b debug0 %b want 00 0", bus.dpc_write, bus.debug[0]); end
        bus.instr_end = 2'b01;
        bus.pc_reg[31:0] = 32'h204;
        bus.pc_next[31:0] = 32'h208;
        #1;
        vectors++; if (bus.dpc_write[0] !== 1'b1 || bus.cause_out[2:0] !== 3'd4 || bus.dpc_out[31:0] !== 32'h208) begin miscompares++; $display("FAIL step_entry: write %b cause %0d dpc %h want 1 4 208", bus.dpc_write[0], bus.cause_out[2:0], bus.dpc_out[31:0]); end
        tick();
        bus.instr_end = 2'b00;
        bus.step_en = 2'b00;
        bus.core_halted = 2'b01;
        tick();
        bus.core_halted = 2'b00;
        #1;
        vectors++; if (bus.halted !== 2'b11) begin miscompares++; $display("FAIL step_halted: halted %b want 11", bus.halted); end
    endtask

    task automatic test_ebreak_priority();
        bus.hart_sel = 2'b01;
        bus.resume_req = 1'b1;
        tick();
        bus.resume_req = 1'b0;
        bus.core_resumed = 2'b01;
        tick();
        bus.core_resumed = 2'b00;
        bus.ebreak_hit = 2'b01;
        bus.halt_req = 1'b1;
        bus.instr_end = 2'b01;
        bus.pc_reg[31:0] = 32'h300;
        bus.pc_next[31:0] = 32'h304;
        #1;
        vectors++; if (bus.dpc_write !== 2'b01 || bus.cause_out[2:0] !== 3'd1 || bus.dpc_out[31:0] !== 32'h300) begin miscompares++; $display("FAIL ebreak_entry: write %b cause %0d dpc %h want 01 1 300", bus.dpc_write, bus.cause_out[2:0], bus.dpc_out[31:0]); end
        tick();
        bus.ebreak_hit = 2'b00;
        bus.instr_end = 2'b00;
        bus.core_halted = 2'b01;
        tick();
        bus.core_halted = 2'b00;
        bus.halt_req = 1'b0;
        #1;
        vectors++; if (bus.halted !== 2'b11 || bus.resumeack[0] !== 1'b1) begin miscompares++; $display("FAIL ebreak_halted: halted %b ack0 %b want 11 1", bus.halted, bus.resumeack[0]); end
    endtask

    task automatic test_halt_beats_resume();
        bus.hart_sel = 2'b01;
        bus.halt_req = 1'b1;
        bus.resume_req = 1'b1;
        #1;
        vectors++; if (bus.dpc_write !== 2'b00) begin miscompares++; $display("FAIL collide_strobe: dpc_write %b want 00", bus.dpc_write); end
        tick();
        bus.resume_req = 1'b0;
        bus.halt_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++; if (bus.halted[0] !== 1'b1 || bus.resume_go !== 2'b00 || bus.resumeack[0] !== 1'b1) begin miscompares++; $display("FAIL collide_hold: halted0 %b resume_go %b ack0 %b want 1 00 1", bus.halted[0], bus.resume_go, bus.resumeack[0]); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [2:0]    c;
        logic [XL-1:0] d;
        logic [NH-1:0] exp_write;
        logic [NH-1:0] sel_h;
        do_reset(NH'($urandom_range(0, 3)));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                rst_n             = ($urandom_range(0, 199) != 0);
                bus.hart_sel      = NH'($urandom_range(0, 3));
                bus.halt_req      = ($urandom_range(0, 7) == 0);
                bus.resume_req    = ($urandom_range(0, 3) == 0);
                bus.ack_havereset = ($urandom_range(0, 15) == 0);
                bus.haltonreset   = NH'($urandom_range(0, 3));
                bus.step_en       = NH'($urandom_range(0, 3)) & NH'($urandom_range(0, 3));
                for (int i = 0; i < NH; i++) begin
                    bus.ebreak_hit[i]   = ($urandom_range(0, 15) == 0);
                    bus.instr_end[i]    = ($urandom_range(0, 1) == 0);
                    bus.core_halted[i]  = ($urandom_range(0, 1) == 0);
                    bus.core_resumed[i] = ($urandom_range(0, 1) == 0);
                end
                bus.pc_reg  = {$urandom(), $urandom()};
                bus.pc_next = {$urandom(), $urandom()};
            end
            #1;
            exp_write = '0;
            for (int i = 0; i < NH; i++) begin
                exp_write[i] = model_entry(i, c, d);
                if (exp_write[i]) begin
                    vectors++; if (bus.cause_out[i*3 +: 3] !== c || bus.dpc_out[i*XL +: XL] !== d) begin miscompares++; $display("FAIL rnd_capture hart%0d cyc %0d: cause %0d dpc %h want %0d %h", i, cyc, bus.cause_out[i*3 +: 3], bus.dpc_out[i*XL +: XL], c, d); end
                end
            end
            sel_h = m_halted & bus.hart_sel;
            vectors++; if (bus.dpc_write !== exp_write) begin miscompares++; $display("FAIL rnd_dpc_write cyc %0d: got %b want %b", cyc, bus.dpc_write, exp_write); end
            vectors++; if (bus.debug !== (m_debug | exp_write)) begin miscompares++; $display("FAIL rnd_debug cyc %0d: got %b want %b", cyc, bus.debug, m_debug | exp_write); end
            vectors++; if (bus.halted !== m_halted) begin miscompares++; $display("FAIL rnd_halted cyc %0d: got %b want %b", cyc, bus.halted, m_halted); end
            vectors++; if (bus.resume_go !== m_resuming) begin miscompares++; $display("FAIL rnd_resume_go cyc %0d: got %b want %b", cyc, bus.resume_go, m_resuming); end
            vectors++; if (bus.resumeack !== m_ack) begin miscompares++; $display("FAIL rnd_resumeack cyc %0d: got %b want %b", cyc, bus.resumeack, m_ack); end
            vectors++; if (bus.havereset !== m_hr) begin miscompares++; $display("FAIL rnd_havereset cyc %0d: got %b want %b", cyc, bus.havereset, m_hr); end
            vectors++; if (bus.anyhalted !== (sel_h != '0)) begin miscompares++; $display("FAIL rnd_anyhalted cyc %0d: got %b want %b", cyc, bus.anyhalted, sel_h != '0); end
            vectors++; if (bus.allhalted !== (bus.hart_sel != '0 && sel_h == bus.hart_sel)) begin miscompares++; $display("FAIL rnd_allhalted cyc %0d: got %b want %b", cyc, bus.allhalted, bus.hart_sel != '0 && sel_h == bus.hart_sel); end
            tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        m_debug = '0; m_halted = '0; m_resuming = '0; m_ack = '0; m_hr = '1; m_first = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_halt_both();
        test_resume_one();
        test_step();
        test_ebreak_priority();
        test_halt_beats_resume();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
